// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// The address check is kept here so every user of the word store agrees on it.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

   localparam int WORD_W     = 32;
   localparam int BYTE_OFF_W = 2;

   // Word-aligned and inside a store of 2**idx_w words.
   function automatic logic addr_ok(input logic [WORD_W-1:0] addr, input int idx_w);
      return (addr[BYTE_OFF_W-1:0] == '0) && ((addr >> (idx_w + BYTE_OFF_W)) == '0);
   endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// Single-port word store: synchronous write, registered read, contents never reset.
module dm_ram_array #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     en_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: latches one request, waits LATENCY cycles, performs the
// word access and reports completion with a one-cycle mem_ready pulse.
module data_memory_responder
   import mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [WORD_W-1:0] address,
   input  logic [WORD_W-1:0] write_data,
   output logic [WORD_W-1:0] read_data,
   output logic              mem_ready,
   output logic              mem_error
);

   localparam int IDX_W = $clog2(DEPTH);

   mem_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic              err_q, err_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              access;
   logic [WORD_W-1:0] ram_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      err_d   = err_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               wr_d    = mem_write;
               err_d   = !addr_ok(address, IDX_W) || (mem_read && mem_write);
               idx_d   = address[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
               wdata_d = write_data;
               cnt_d   = 4'(LATENCY);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Rejected requests never touch the store.
               access  = !err_q;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   dm_ram_array #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_ram (
      .clk     (clk),
      .en_i    (access),
      .we_i    (wr_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   assign mem_ready = (state_q == DONE);
   assign mem_error = (state_q == DONE) && err_q;
   assign read_data = ((state_q == DONE) && !err_q && !wr_q) ? ram_rdata : '0;

endmodule
